// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register-file target.
// Holds the FSM state encoding, bus bit meanings and the address-match rule.
package i2c_target_regs_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // Released open-drain lines float high, so synchronizers start there.
    localparam logic BUS_IDLE_LEVEL = 1'b1;

    // Address 0 is the general call, which this target never answers.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[7:1] != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_target_regs_sync_edge.sv
// Input synchronizer for one bus line: a chain of flip-flops followed by
// single-cycle rise and fall pulses derived from the synchronized level.
module i2c_sync_edge
    import i2c_target_regs_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= {STAGES{BUS_IDLE_LEVEL}};
            r_prev <= BUS_IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_line};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target serving an external register file: address match, register
// pointer, burst writes and sequential reads over an open-drain SDA line.
module i2c_target_regs
    import i2c_target_regs_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL_BUS,
    inout  wire        SDA_BUS,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic       w_scl, w_scl_rise, w_scl_fall;
    logic       w_sda, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop;
    logic [7:0] w_rx_byte;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic       r_sda_low;
    logic       r_ack_drv;
    logic       r_rw;
    logic       r_re_d;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (SCL_BUS),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .i_line  (SDA_BUS),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign SDA_BUS   = r_sda_low ? 1'b0 : 1'bz;
    assign w_start   = w_scl & w_sda_fall;
    assign w_stop    = w_scl & w_sda_rise;
    assign w_rx_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sda_low <= 1'b0;
            r_ack_drv <= 1'b0;
            r_rw      <= I2C_WRITE;
            r_re_d    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            r_re_d <= reg_re;
            // Read data arrives one cycle after the request; capture it for serialisation.
            if (r_re_d) r_shift <= reg_rdata;
            if (reg_we) reg_addr <= reg_addr + 8'd1;

            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= '0;
                r_sda_low <= 1'b0;
                r_ack_drv <= 1'b0;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_sda_low <= 1'b0;
                r_ack_drv <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_REG, ST_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= '0;
                                if (r_state == ST_ADDR) begin
                                    r_rw <= w_sda;
                                    if (addr_match(w_rx_byte, SLAVE_ADDR)) begin
                                        r_state <= ST_ADDR_ACK;
                                        busy    <= 1'b1;
                                    end else begin
                                        r_state <= ST_IGNORE;
                                        busy    <= 1'b0;
                                    end
                                end else if (r_state == ST_REG) begin
                                    reg_addr <= w_rx_byte;
                                    r_state  <= ST_REG_ACK;
                                end else begin
                                    reg_wdata <= w_rx_byte;
                                    reg_we    <= 1'b1;
                                    r_state   <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end

                    // First SCL fall starts the ACK drive, the second one ends it.
                    ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_ack_drv <= 1'b1;
                                r_sda_low <= ~I2C_ACK;
                                if (r_state == ST_ADDR_ACK && r_rw == I2C_READ) reg_re <= 1'b1;
                            end else begin
                                r_ack_drv <= 1'b0;
                                r_sda_low <= 1'b0;
                                r_bit_cnt <= '0;
                                if (r_state == ST_ADDR_ACK && r_rw == I2C_READ) begin
                                    r_state   <= ST_RDATA;
                                    r_sda_low <= ~r_shift[7];
                                    r_shift   <= {r_shift[6:0], 1'b0};
                                    r_bit_cnt <= 4'd1;
                                end else if (r_state == ST_ADDR_ACK) begin
                                    r_state <= ST_REG;
                                end else begin
                                    r_state <= ST_WDATA;
                                end
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_low <= 1'b0;
                                r_state   <= ST_RACK;
                            end else begin
                                r_sda_low <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_RACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == I2C_ACK) begin
                                reg_addr  <= reg_addr + 8'd1;
                                reg_re    <= 1'b1;
                                r_bit_cnt <= '0;
                                r_state   <= ST_RDATA;
                            end else begin
                                r_state <= ST_IGNORE;
                                busy    <= 1'b0;
                            end
                        end
                    end

                    ST_IDLE, ST_IGNORE: begin
                        r_sda_low <= 1'b0;
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-level I2C master plus a transaction-level
// model of pointer, strobes and read data, with directed and random transfers.
module tb_i2c_target_regs;

    localparam logic [6:0] DEV = 7'h68;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       mSdaLow;
    wire        sdaBus;
    logic [7:0] regAddr, regWdata;
    logic [7:0] regRdata = 8'h00;
    logic       regWe, regRe, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mPtr = 8'h00;
    logic [7:0] expWeAddr[$];
    logic [7:0] expWeData[$];
    logic [7:0] expReAddr[$];
    int         weCount = 0;
    int         reCount = 0;
    logic [7:0] lastWeAddr, lastWeData, lastReAddr;
    logic [7:0] popA, popD;

    assign sdaBus = mSdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 clk = ~clk;

    i2c_target_regs #(.SLAVE_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .SCL_BUS   (scl),
        .SDA_BUS   (sdaBus),
        .reg_addr  (regAddr),
        .reg_wdata (regWdata),
        .reg_we    (regWe),
        .reg_re    (regRe),
        .reg_rdata (regRdata),
        .busy      (busy)
    );

    // External register file: read data is a fixed function of the address.
    always @(negedge clk) begin
        if (regRe) regRdata <= regAddr ^ 8'h5A;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Every strobe must match the next one the transaction model predicted.
    always @(negedge clk) begin
        if (reset && regWe) begin
            weCount++;
            lastWeAddr = regAddr;
            lastWeData = regWdata;
            checks++;
            if (expWeAddr.size() == 0) begin
                errors++;
                $display("[TB] FAIL reg_we strobe: got addr %0h data %0h, required no strobe", regAddr, regWdata);
            end else begin
                popA = expWeAddr.pop_front();
                popD = expWeData.pop_front();
                if (regAddr !== popA || regWdata !== popD) begin
                    errors++;
                    $display("[TB] FAIL reg_we strobe: got addr %0h data %0h, required addr %0h data %0h",
                             regAddr, regWdata, popA, popD);
                end
            end
        end
        if (reset && regRe) begin
            reCount++;
            lastReAddr = regAddr;
            checks++;
            if (expReAddr.size() == 0) begin
                errors++;
                $display("[TB] FAIL reg_re strobe: got addr %0h, required no strobe", regAddr);
            end else begin
                popA = expReAddr.pop_front();
                if (regAddr !== popA) begin
                    errors++;
                    $display("[TB] FAIL reg_re strobe: got addr %0h, required addr %0h", regAddr, popA);
                end
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock: SDA set mid-low, sampled mid-high, SCL left low.
    task automatic applyStimulus(input logic sdaBit, output logic sampled);
        waitClk(4);
        mSdaLow = ~sdaBit;
        waitClk(4);
        scl = 1'b1;
        waitClk(4);
        sampled = sdaBus;
        waitClk(4);
        scl = 1'b0;
    endtask

    task automatic busStart();
        if (!scl) begin
            waitClk(4);
            mSdaLow = 1'b0;
            waitClk(4);
            scl = 1'b1;
            waitClk(8);
        end
        mSdaLow = 1'b1;
        waitClk(8);
        scl = 1'b0;
    endtask

    task automatic busStop();
        waitClk(4);
        mSdaLow = 1'b1;
        waitClk(4);
        scl = 1'b1;
        waitClk(8);
        mSdaLow = 1'b0;
        waitClk(8);
    endtask

    task automatic sendByte(input logic [7:0] data, input logic expAck, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(data[i], s);
            if (data[i]) checkOutput({name, " released bit"}, s, 1);
        end
        applyStimulus(1'b1, s);
        checkOutput({name, " ack"}, s, expAck);
    endtask

    task automatic readByte(input logic masterNack, output logic [7:0] data);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            data[i] = s;
        end
        applyStimulus(masterNack, s);
        if (masterNack) checkOutput("master nack bit", s, 1);
    endtask

    task automatic writeTxn(input logic [6:0] dev, input logic [7:0] regPtr,
                            input logic [7:0] bytes [8], input int n);
        logic hit;
        hit = (dev == DEV) && (dev != 7'd0);
        busStart();
        sendByte({dev, 1'b0}, ~hit, "write addr");
        checkOutput("busy after write addr", busy, hit);
        if (hit) mPtr = regPtr;
        sendByte(regPtr, ~hit, "write reg");
        for (int k = 0; k < n; k++) begin
            if (hit) begin
                expWeAddr.push_back(mPtr);
                expWeData.push_back(bytes[k]);
                mPtr = mPtr + 8'd1;
            end
            sendByte(bytes[k], ~hit, "write data");
        end
        busStop();
        waitClk(4);
        checkOutput("busy after stop", busy, 0);
        checkOutput("reg_addr after write", regAddr, mPtr);
    endtask

    task automatic readTxn(input logic [6:0] dev, input logic [7:0] regPtr, input int n,
                           output logic [7:0] got [8]);
        logic       hit;
        logic       last;
        logic [7:0] d;
        hit = (dev == DEV) && (dev != 7'd0);
        busStart();
        sendByte({dev, 1'b0}, ~hit, "read addr w");
        if (hit) mPtr = regPtr;
        sendByte(regPtr, ~hit, "read reg");
        busStart();
        if (hit) expReAddr.push_back(mPtr);
        sendByte({dev, 1'b1}, ~hit, "read addr r");
        checkOutput("busy in read", busy, hit);
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            if (hit && !last) expReAddr.push_back(mPtr + 8'd1);
            readByte(last, d);
            got[k] = d;
            if (hit) begin
                checkOutput("read data", d, mPtr ^ 8'h5A);
                if (!last) mPtr = mPtr + 8'd1;
            end else begin
                checkOutput("read data unaddressed", d, 8'hFF);
            end
        end
        checkOutput("busy after nack", busy, 0);
        busStop();
        waitClk(4);
        checkOutput("reg_addr after read", regAddr, mPtr);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no end of test, required completion within 90000 clocks");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [7:0] wbuf [8];
        logic [7:0] got [8];
        logic [7:0] abortByte;
        logic [7:0] addrW;
        logic       s;
        int         weBase, reBase, n;
        logic [6:0] dev;
        logic [7:0] ptr;

        reset = 1'b0;
        scl = 1'b1;
        mSdaLow = 1'b0;
        for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;
        waitClk(4);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset reg_addr", regAddr, 8'h00);
        checkOutput("reset reg_wdata", regWdata, 8'h00);
        checkOutput("reset reg_we", regWe, 0);
        checkOutput("reset reg_re", regRe, 0);
        checkOutput("reset sda", sdaBus, 1);
        reset = 1'b1;
        waitClk(6);

        $display("[TB] single register write");
        weBase = weCount;
        wbuf[0] = 8'h00;
        writeTxn(DEV, 8'h6B, wbuf, 1);
        checkOutput("write strobe count", weCount - weBase, 1);
        checkOutput("write strobe addr", lastWeAddr, 8'h6B);
        checkOutput("write strobe data", lastWeData, 8'h00);
        checkOutput("write final pointer", regAddr, 8'h6C);

        $display("[TB] burst write across pointer wrap");
        weBase = weCount;
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        writeTxn(DEV, 8'hFE, wbuf, 2);
        checkOutput("burst strobe count", weCount - weBase, 2);
        checkOutput("burst last strobe addr", lastWeAddr, 8'hFF);
        checkOutput("burst last strobe data", lastWeData, 8'h22);
        checkOutput("burst final pointer", regAddr, 8'h00);

        $display("[TB] combined read");
        weBase = weCount;
        reBase = reCount;
        readTxn(DEV, 8'h75, 2, got);
        checkOutput("combined read byte0", got[0], 8'h2F);
        checkOutput("combined read byte1", got[1], 8'h2C);
        checkOutput("combined read strobes", reCount - reBase, 2);
        checkOutput("combined read last re addr", lastReAddr, 8'h76);
        checkOutput("combined read no writes", weCount - weBase, 0);

        $display("[TB] address mismatch");
        weBase = weCount;
        reBase = reCount;
        writeTxn(7'h50, 8'h01, wbuf, 0);
        checkOutput("mismatch write strobes", weCount - weBase, 0);
        checkOutput("mismatch read strobes", reCount - reBase, 0);

        $display("[TB] stop during read data");
        abortByte = 8'h2F;
        busStart();
        sendByte({DEV, 1'b0}, 1'b0, "abort addr w");
        mPtr = 8'h75;
        sendByte(8'h75, 1'b0, "abort reg");
        busStart();
        expReAddr.push_back(8'h75);
        sendByte({DEV, 1'b1}, 1'b0, "abort addr r");
        for (int i = 7; i >= 4; i--) begin
            applyStimulus(1'b1, s);
            checkOutput("abort data bit", s, abortByte[i]);
        end
        waitClk(4);
        mSdaLow = 1'b1;
        waitClk(4);
        scl = 1'b1;
        waitClk(4);
        mSdaLow = 1'b0;
        waitClk(6);
        checkOutput("abort sda released", sdaBus, 1);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort pointer", regAddr, 8'h75);
        weBase = weCount;
        wbuf[0] = 8'h3C;
        writeTxn(DEV, 8'h10, wbuf, 1);
        checkOutput("after abort strobe count", weCount - weBase, 1);

        $display("[TB] reset during address ack");
        addrW = {DEV, 1'b0};
        busStart();
        for (int i = 7; i >= 0; i--) applyStimulus(addrW[i], s);
        waitClk(4);
        mSdaLow = 1'b0;
        waitClk(2);
        checkOutput("ack driven before reset", sdaBus, 0);
        reset = 1'b0;
        waitClk(1);
        checkOutput("reset mid-ack sda", sdaBus, 1);
        checkOutput("reset mid-ack busy", busy, 0);
        checkOutput("reset mid-ack reg_addr", regAddr, 8'h00);
        checkOutput("reset mid-ack reg_wdata", regWdata, 8'h00);
        checkOutput("reset mid-ack reg_we", regWe, 0);
        checkOutput("reset mid-ack reg_re", regRe, 0);
        waitClk(2);
        reset = 1'b1;
        mPtr = 8'h00;
        waitClk(2);
        scl = 1'b1;
        waitClk(12);
        checkOutput("idle after reset sda", sdaBus, 1);
        checkOutput("idle after reset busy", busy, 0);

        $display("[TB] random transfers");
        for (int t = 0; t < 20; t++) begin
            dev = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DEV;
            ptr = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) writeTxn(dev, ptr, wbuf, n);
            else readTxn(dev, ptr, n, got);
        end

        waitClk(10);
        checkOutput("pending write strobes", expWeAddr.size(), 0);
        checkOutput("pending read strobes", expReAddr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
